gpu_cmd_sequencer: RTL and testbench

Command sequencer sitting directly upstream of the voxel GPU's register slave port. It buffers a stream of (address, data) register commands in a FIFO and replays them to the GPU over an Avalon-MM master. For operation-triggering writes it waits for the GPU interrupt and acknowledges it with a status read, so the host can queue an entire frame (camera setup, coordinate, raycast, rasterize, shade and write-out commands) without servicing every interrupt.

---
 rtl/gpu_cmd_sequencer.sv | 171 +++++++++++++++++
 tb/tb_gpu_cmd_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_cmd_sequencer.sv
// Purpose : buffers (address, data) GPU register commands and replays them over an
//           Avalon-MM master, waiting for and acknowledging the GPU irq after each
//           operation-triggering write (addresses 0x00-0x03).
// Latency : command accepted in cycle N into an empty FIFO is driven on the bus in N+2;
//           irq seen in cycle K gives the status read in K+1.
// Backpressure: cmd_ready drops when the FIFO holds DEPTH entries; all bus outputs are
//           held stable while m_waitrequest is high.
// Ports   : clock/reset (sync, active-low); cmd_* host command push; m_* Avalon-MM
//           master to GPU s1; gpu_irq; clear_error leaves HALT; busy/error/error_code/
//           done_count status.
module gpu_cmd_sequencer #(
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 1048576
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_address,
   input  logic [31:0] cmd_data,
   output logic [7:0]  m_address,
   output logic        m_write,
   output logic        m_read,
   output logic [31:0] m_writedata,
   input  logic [31:0] m_readdata,
   input  logic        m_waitrequest,
   input  logic        gpu_irq,
   input  logic        clear_error,
   output logic        busy,
   output logic        error,
   output logic [1:0]  error_code,
   output logic [15:0] done_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [7:0] STATUS_ADDR = 8'h0f;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_IRQ,
      S_ACK,
      S_HALT,
      S_CLEAR
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;

   // Command FIFO: {address, data} per entry.
   logic [39:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [CW-1:0]   count;
   logic            push;
   logic            pop;
   logic [39:0]     head;
   logic            head_is_trigger;

   assign cmd_ready       = (count != CW'(DEPTH));
   assign push            = cmd_valid && cmd_ready;
   // The head is only consumed when the write carrying it is accepted by the GPU.
   assign pop             = (state == S_ISSUE) && !m_waitrequest;
   assign head            = mem[rd_ptr];
   assign head_is_trigger = (head[39:34] == 6'd0);

   assign busy  = (state != S_IDLE) || (count != '0);
   assign error = (state == S_HALT);

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clock) begin
      if (push) begin
         mem[wr_ptr] <= {cmd_address, cmd_data};
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state       <= S_IDLE;
         timer       <= '0;
         done_count  <= '0;
         error_code  <= 2'd0;
         m_write     <= 1'b0;
         m_read      <= 1'b0;
         m_address   <= 8'h00;
         m_writedata <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (count != '0) begin
                  state       <= S_ISSUE;
                  m_write     <= 1'b1;
                  m_address   <= head[39:32];
                  m_writedata <= head[31:0];
               end
            end
            S_ISSUE: begin
               if (!m_waitrequest) begin
                  m_write <= 1'b0;
                  if (head_is_trigger) begin
                     state <= S_WAIT_IRQ;
                     timer <= '0;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_WAIT_IRQ: begin
               if (gpu_irq) begin
                  state     <= S_ACK;
                  m_read    <= 1'b1;
                  m_address <= STATUS_ADDR;
               end else if (timer == TW'(TIMEOUT - 1)) begin
                  state      <= S_HALT;
                  error_code <= 2'd1;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            S_ACK: begin
               if (!m_waitrequest) begin
                  m_read <= 1'b0;
                  if (m_readdata == 32'h0) begin
                     done_count <= done_count + 16'd1;
                     state      <= S_IDLE;
                  end else begin
                     state      <= S_HALT;
                     error_code <= 2'd2;
                  end
               end
            end
            S_HALT: begin
               // Writing 1 to the status register clears the GPU-side fault.
               if (clear_error) begin
                  state       <= S_CLEAR;
                  m_write     <= 1'b1;
                  m_address   <= STATUS_ADDR;
                  m_writedata <= 32'h1;
               end
            end
            S_CLEAR: begin
               if (!m_waitrequest) begin
                  m_write    <= 1'b0;
                  error_code <= 2'd0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Purpose : self-checking bench for gpu_cmd_sequencer with a bus-transaction scoreboard.
// Latency : checks issue latency (N+2), irq-to-read (K+1) and the timeout window.
// Backpressure: exercises FIFO full with m_waitrequest held high.
module tb_gpu_cmd_sequencer;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 64;

   logic        clock;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_address;
   logic [31:0] cmd_data;
   logic [7:0]  m_address;
   logic        m_write;
   logic        m_read;
   logic [31:0] m_writedata;
   logic [31:0] m_readdata;
   logic        m_waitrequest;
   logic        gpu_irq;
   logic        clear_error;
   logic        busy;
   logic        error;
   logic [1:0]  error_code;
   logic [15:0] done_count;

   gpu_cmd_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clock        (clock),
      .reset        (reset),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_address  (cmd_address),
      .cmd_data     (cmd_data),
      .m_address    (m_address),
      .m_write      (m_write),
      .m_read       (m_read),
      .m_writedata  (m_writedata),
      .m_readdata   (m_readdata),
      .m_waitrequest(m_waitrequest),
      .gpu_irq      (gpu_irq),
      .clear_error  (clear_error),
      .busy         (busy),
      .error        (error),
      .error_code   (error_code),
      .done_count   (done_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  addr;
      logic [31:0] data;
      int          irq_dly;
      logic [15:0] exp_done;
   } vec_t;

   vec_t        vecs [6];
   int          checks   = 0;
   int          failures = 0;
   int          cyc_n    = 0;
   int          overlap  = 0;
   int          hold_bad = 0;
   bit          acc, hs_w, hs_r, s_busy, s_err;
   bit          hold_prev = 1'b0;
   logic [41:0] prev_out  = '0;
   logic [40:0] exp_q [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // One clock: sample everything on the falling edge, score bus handshakes,
   // then return 1 time unit after the rising edge for the next drive.
   task automatic cyc();
      logic [40:0] txn;
      logic [40:0] e;
      @(negedge clock);
      cyc_n++;
      acc    = cmd_valid && cmd_ready;
      hs_w   = reset && m_write && !m_waitrequest;
      hs_r   = reset && m_read && !m_waitrequest;
      s_busy = busy;
      s_err  = error;
      if (reset) begin
         if (m_write && m_read) overlap++;
         if (hold_prev && ({m_write, m_read, m_address, m_writedata} !== prev_out)) hold_bad++;
         if (hs_w || hs_r) begin
            txn = {m_read, m_address, m_read ? 32'h0 : m_writedata};
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL bus_unexpected actual=%0h required=none", txn);
            end else begin
               e = exp_q.pop_front();
               check("bus_txn", 64'(txn), 64'(e));
            end
         end
      end
      hold_prev = reset && (m_write || m_read) && m_waitrequest;
      prev_out  = {m_write, m_read, m_address, m_writedata};
      @(posedge clock);
      #1;
   endtask

   // mode: 0 = no bus expectation, 1 = write, 2 = write then status read
   task automatic push(input logic [7:0] a, input logic [31:0] d, input int mode);
      bit got;
      got = 1'b0;
      cmd_valid   = 1'b1;
      cmd_address = a;
      cmd_data    = d;
      for (int i = 0; i < 100 && !got; i++) begin
         cyc();
         got = acc;
      end
      cmd_valid = 1'b0;
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL push_timeout actual=not_accepted required=accepted");
      end else begin
         if (mode >= 1) exp_q.push_back({1'b0, a, d});
         if (mode == 2) exp_q.push_back({1'b1, 8'h0f, 32'h0});
      end
   endtask

   // ev: 0 = write handshake, 1 = read handshake, 2 = idle, 3 = error
   task automatic wait_ev(input int ev, input string name, output int at);
      bit hit;
      hit = 1'b0;
      at  = -1;
      for (int i = 0; i < 300 && !hit; i++) begin
         cyc();
         case (ev)
            0:       hit = hs_w;
            1:       hit = hs_r;
            2:       hit = !s_busy;
            default: hit = s_err;
         endcase
      end
      if (hit) at = cyc_n;
      else begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_event required=event", name);
      end
   endtask

   initial begin
      int n_acc, n_w, n_r, k, e, dummy, extra;
      bit trig;

      vecs[0] = '{8'h10, 32'h100, -1, 16'd0};
      vecs[1] = '{8'h11, 32'h200, -1, 16'd0};
      vecs[2] = '{8'h12, 32'h300, -1, 16'd0};
      vecs[3] = '{8'h03, 32'h0,   20, 16'd1};
      vecs[4] = '{8'h01, 32'h5,    0, 16'd2};
      vecs[5] = '{8'h1e, 32'h7,   -1, 16'd2};

      reset = 1'b0; cmd_valid = 1'b0; cmd_address = 8'h0; cmd_data = 32'h0;
      m_readdata = 32'h0; m_waitrequest = 1'b0; gpu_irq = 1'b0; clear_error = 1'b0;
      repeat (3) cyc();
      check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
      check("rst_m_write", 64'(m_write), 64'(0));
      check("rst_m_read", 64'(m_read), 64'(0));
      check("rst_m_address", 64'(m_address), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_error_code", 64'(error_code), 64'(0));
      check("rst_done", 64'(done_count), 64'(0));
      reset = 1'b1;
      cyc();

      // Table-driven: each vector from an idle, empty sequencer.
      for (int v = 0; v < 6; v++) begin
         trig = (vecs[v].addr[7:2] == 6'd0);
         push(vecs[v].addr, vecs[v].data, trig ? 2 : 1);
         n_acc = cyc_n;
         wait_ev(0, "vec_write", n_w);
         check("issue_latency", 64'(n_w - n_acc), 64'(2));
         if (trig) begin
            repeat (vecs[v].irq_dly) cyc();
            gpu_irq = 1'b1;
            k = cyc_n + 1;
            wait_ev(1, "vec_read", n_r);
            gpu_irq = 1'b0;
            check("irq_to_read", 64'(n_r - k), 64'(1));
         end
         wait_ev(2, "vec_idle", dummy);
         check("vec_done", 64'(done_count), 64'(vecs[v].exp_done));
         check("vec_error", 64'(error), 64'(0));
         check("vec_queue_drained", 64'(exp_q.size()), 64'(0));
      end

      // irq and clear_error are ignored while idle.
      gpu_irq = 1'b1; clear_error = 1'b1;
      repeat (3) cyc();
      gpu_irq = 1'b0; clear_error = 1'b0;
      check("ignore_busy", 64'(s_busy), 64'(0));
      check("ignore_done", 64'(done_count), 64'(2));

      // Timeout: 64 WAIT_IRQ cycles, error visible the cycle after.
      push(8'h00, 32'h0, 1);
      wait_ev(0, "to_write", n_w);
      wait_ev(3, "to_error", e);
      check("timeout_cycles", 64'(e - n_w), 64'(65));
      check("timeout_code", 64'(error_code), 64'(1));
      exp_q.push_back({1'b0, 8'h0f, 32'h1});
      clear_error = 1'b1;
      cyc();
      clear_error = 1'b0;
      wait_ev(2, "clr_idle", dummy);
      check("clear_error_flag", 64'(error), 64'(0));
      check("clear_code", 64'(error_code), 64'(0));
      check("clear_queue", 64'(exp_q.size()), 64'(0));

      // Bad status read: HALT holds later commands until cleared.
      m_readdata = 32'h2;
      push(8'h02, 32'h9, 2);
      wait_ev(0, "bad_write", dummy);
      gpu_irq = 1'b1;
      wait_ev(1, "bad_read", dummy);
      gpu_irq = 1'b0;
      wait_ev(3, "bad_error", dummy);
      m_readdata = 32'h0;
      check("bad_code", 64'(error_code), 64'(2));
      push(8'h13, 32'h1300, 0);
      push(8'h14, 32'h1400, 0);
      repeat (5) cyc();
      check("halt_busy", 64'(busy), 64'(1));
      check("halt_error", 64'(error), 64'(1));
      check("halt_done", 64'(done_count), 64'(2));
      exp_q.push_back({1'b0, 8'h0f, 32'h1});
      exp_q.push_back({1'b0, 8'h13, 32'h1300});
      exp_q.push_back({1'b0, 8'h14, 32'h1400});
      clear_error = 1'b1;
      cyc();
      clear_error = 1'b0;
      wait_ev(2, "resume_idle", dummy);
      check("resume_queue", 64'(exp_q.size()), 64'(0));
      check("resume_code", 64'(error_code), 64'(0));

      // Fill the FIFO under waitrequest.
      m_waitrequest = 1'b1;
      for (int i = 0; i < DEPTH; i++) push(8'(8'h20 + i), 32'hA000 + 32'(i), 1);
      check("full_ready", 64'(cmd_ready), 64'(0));
      extra = 0;
      cmd_valid = 1'b1; cmd_address = 8'h55; cmd_data = 32'h55;
      repeat (4) begin
         cyc();
         if (acc) extra++;
      end
      cmd_valid = 1'b0;
      check("full_no_accept", 64'(extra), 64'(0));
      check("held_write", 64'(m_write), 64'(1));
      check("held_addr", 64'(m_address), 64'(8'h20));
      check("held_data", 64'(m_writedata), 64'(32'hA000));
      m_waitrequest = 1'b0;
      wait_ev(2, "drain_idle", dummy);
      check("drain_queue", 64'(exp_q.size()), 64'(0));
      check("no_rw_overlap", 64'(overlap), 64'(0));
      check("hold_stable", 64'(hold_bad), 64'(0));

      // Reset during WAIT_IRQ with 4 queued commands.
      push(8'h01, 32'h11, 1);
      wait_ev(0, "rst_write", dummy);
      for (int i = 0; i < 4; i++) push(8'(8'h30 + i), 32'(i), 0);
      cyc();
      reset = 1'b0;
      cyc();
      reset = 1'b1;
      check("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
      check("mid_rst_m_write", 64'(m_write), 64'(0));
      check("mid_rst_m_read", 64'(m_read), 64'(0));
      check("mid_rst_m_address", 64'(m_address), 64'(0));
      check("mid_rst_m_writedata", 64'(m_writedata), 64'(0));
      check("mid_rst_busy", 64'(busy), 64'(0));
      check("mid_rst_error", 64'(error), 64'(0));
      check("mid_rst_code", 64'(error_code), 64'(0));
      check("mid_rst_done", 64'(done_count), 64'(0));
      repeat (10) cyc();
      check("post_rst_idle", 64'(s_busy), 64'(0));
      check("post_rst_queue", 64'(exp_q.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
